// File: rtl/data_mem_be_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : data_mem_be_if
// Brief    : Load/store request bus between the CPU and the byte-enabled data RAM.
// Revision : 1.0
//------------------------------------------------------------------------------
interface data_mem_be_if;
  logic        req_valid;
  logic        req_ready;
  logic        rd;
  logic        wr;
  logic [1:0]  size;
  logic        sext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rvalid;
  logic        err;
  logic        init_done;

  modport master (
    output req_valid, rd, wr, size, sext, addr, wdata,
    input  req_ready, rdata, rvalid, err, init_done
  );

  modport slave (
    input  req_valid, rd, wr, size, sext, addr, wdata,
    output req_ready, rdata, rvalid, err, init_done
  );
endinterface
`default_nettype wire

// File: rtl/data_mem_be.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : data_mem_be
// Brief    : Byte-enabled data RAM with sign/zero-extending loads, fault pulse
//            and a post-reset zero-clear sweep.
// Revision : 1.0
//------------------------------------------------------------------------------
module data_mem_be #(
  parameter int         RAM_SIZE       = 256,
  parameter logic [3:0] IO_PREFIX      = 4'h4,
  parameter bit         CLEAR_ON_RESET = 1'b1,
  parameter bit         CHECK_RANGE    = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  data_mem_be_if.slave  bus
);
  localparam int            AW     = $clog2(RAM_SIZE);
  localparam logic [AW-1:0] c_LAST = AW'(RAM_SIZE - 1);

  typedef enum logic [0:0] {S_INIT = 1'b0, S_RUN = 1'b1} state_t;

  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_cnt, w_cnt_nxt;
  logic          w_clr_we;
  logic          w_run;

  logic [31:0]   r_mem [RAM_SIZE];
  logic [31:0]   r_rword;
  logic          r_rvalid, r_err, r_lio, r_lsext;
  logic [1:0]    r_lsize, r_llane;

  logic          w_accept, w_misalign, w_upper_nz, w_fault, w_io;
  logic          w_st_we, w_ld;
  logic [AW-1:0] w_idx;
  logic [3:0]    w_be;
  logic [31:0]   w_wlanes;
  logic [7:0]    w_lane_b;
  logic [15:0]   w_lane_h;
  logic [31:0]   w_ext;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_clr_we    = 1'b0;
    w_run       = 1'b0;
    case (r_state)
      S_INIT: begin
        if (CLEAR_ON_RESET) begin
          w_clr_we = 1'b1;
          if (r_cnt == c_LAST) w_state_nxt = S_RUN;
          else                 w_cnt_nxt   = r_cnt + 1'b1;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN:   w_run = 1'b1;
      default: w_state_nxt = S_INIT;
    endcase
  end

  assign bus.req_ready = w_run;
  assign bus.init_done = w_run;

  // Request decode; faults are judged on the request as presented at accept.
  assign w_accept   = bus.req_valid & w_run & (bus.rd | bus.wr);
  assign w_upper_nz = |bus.addr[27:AW+2];
  assign w_io       = (bus.addr[31:28] == IO_PREFIX);
  assign w_idx      = bus.addr[AW+1:2];

  always_comb begin
    w_misalign = 1'b0;
    case (bus.size)
      2'd1:    w_misalign = bus.addr[0];
      2'd2:    w_misalign = |bus.addr[1:0];
      default: w_misalign = 1'b0;
    endcase
  end

  assign w_fault = (bus.rd & bus.wr) | (bus.size == 2'd3) | w_misalign
                 | (CHECK_RANGE & w_upper_nz);
  assign w_st_we = w_accept & bus.wr & ~w_fault & ~w_io;
  assign w_ld    = w_accept & bus.rd & ~w_fault;

  always_comb begin
    w_be     = 4'h0;
    w_wlanes = bus.wdata;
    case (bus.size)
      2'd0: begin
        w_be     = 4'b0001 << bus.addr[1:0];
        w_wlanes = {4{bus.wdata[7:0]}};
      end
      2'd1: begin
        w_be     = bus.addr[1] ? 4'b1100 : 4'b0011;
        w_wlanes = {2{bus.wdata[15:0]}};
      end
      default: w_be = 4'hF;
    endcase
  end

  // Read happens before the write on the same edge; rd&wr faults so they never collide.
  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[r_cnt] <= '0;
    end else if (w_st_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wlanes[8*i +: 8];
      end
    end
    r_rword <= r_mem[w_idx];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      r_lio    <= 1'b0;
      r_lsext  <= 1'b0;
      r_lsize  <= 2'd0;
      r_llane  <= 2'd0;
    end else begin
      r_rvalid <= w_ld;
      r_err    <= w_accept & w_fault;
      if (w_ld) begin
        r_lio   <= w_io;
        r_lsext <= bus.sext;
        r_lsize <= bus.size;
        r_llane <= bus.addr[1:0];
      end
    end
  end

  always_comb begin
    w_lane_b = r_rword[{r_llane, 3'b000} +: 8];
    w_lane_h = r_llane[1] ? r_rword[31:16] : r_rword[15:0];
    case (r_lsize)
      2'd0:    w_ext = {{24{r_lsext & w_lane_b[7]}}, w_lane_b};
      2'd1:    w_ext = {{16{r_lsext & w_lane_h[15]}}, w_lane_h};
      default: w_ext = r_rword;
    endcase
  end

  assign bus.rdata  = (r_rvalid & ~r_lio) ? w_ext : 32'h0;
  assign bus.rvalid = r_rvalid;
  assign bus.err    = r_err;
endmodule
`default_nettype wire

// File: tb/tb_data_mem_be.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_data_mem_be
// Brief    : Directed bench for data_mem_be against a byte-array reference model.
// Revision : 1.0
//------------------------------------------------------------------------------
module tb_data_mem_be;
  localparam int RAM_SIZE = 256;
  localparam int AW       = 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  data_mem_be_if bus ();

  data_mem_be #(
    .RAM_SIZE       (RAM_SIZE),
    .IO_PREFIX      (4'h4),
    .CLEAR_ON_RESET (1'b1),
    .CHECK_RANGE    (1'b0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  byte unsigned mdl [RAM_SIZE*4];
  int          init_left = 0;
  bit          mdl_on = 1'b0;
  bit          mdl_ready;
  logic        exp_rvalid = 1'b0, exp_err = 1'b0;
  logic [31:0] exp_rdata = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: memory as a flat byte array, outputs derived per request.
  task automatic model_access();
    int          nb;
    int          a;
    logic [31:0] v;
    bit          fault, io;
    nb    = 1 << bus.size;
    a     = int'(bus.addr[AW+1:0]);
    io    = (bus.addr[31:28] == 4'h4);
    fault = (bus.rd && bus.wr) || (bus.size == 2'd3) || ((bus.addr % nb) != 0);
    if (fault) begin
      exp_err = 1'b1;
    end else if (bus.wr) begin
      if (!io) for (int i = 0; i < nb; i++) mdl[a+i] = bus.wdata[8*i +: 8];
    end else begin
      exp_rvalid = 1'b1;
      v = 32'h0;
      if (!io) begin
        for (int i = 0; i < nb; i++) v = v | (32'(mdl[a+i]) << (8*i));
        if (nb == 1 && bus.sext && v[7])  v[31:8]  = '1;
        if (nb == 2 && bus.sext && v[15]) v[31:16] = '1;
      end
      exp_rdata = v;
    end
  endtask

  always @(posedge clk) begin
    if (reset) begin
      mdl_on     = 1'b1;
      init_left  = RAM_SIZE;
      exp_rvalid = 1'b0;
      exp_err    = 1'b0;
      exp_rdata  = 32'h0;
      foreach (mdl[i]) mdl[i] = 8'h00;
    end else begin
      mdl_ready  = (init_left == 0);
      exp_rvalid = 1'b0;
      exp_err    = 1'b0;
      exp_rdata  = 32'h0;
      if (init_left > 0) init_left--;
      if (mdl_ready && bus.req_valid && (bus.rd || bus.wr)) model_access();
    end
  end

  always @(negedge clk) begin
    if (mdl_on) begin
      check("req_ready", {31'b0, bus.req_ready}, {31'b0, init_left == 0});
      check("init_done", {31'b0, bus.init_done}, {31'b0, init_left == 0});
      check("rvalid",    {31'b0, bus.rvalid},    {31'b0, exp_rvalid});
      check("err",       {31'b0, bus.err},       {31'b0, exp_err});
      check("rdata",     bus.rdata,              exp_rdata);
    end
  end

  task automatic req(input logic r, input logic w, input logic [1:0] sz, input logic sx,
                     input logic [31:0] a, input logic [31:0] d);
    bus.rd = r; bus.wr = w; bus.size = sz; bus.sext = sx;
    bus.addr = a; bus.wdata = d; bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0; bus.rd = 1'b0; bus.wr = 1'b0;
  endtask

  task automatic store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    req(1'b0, 1'b1, sz, 1'b0, a, d);
  endtask

  task automatic load(input logic [1:0] sz, input logic sx, input logic [31:0] a,
                      input logic [31:0] exp, input string name);
    req(1'b1, 1'b0, sz, sx, a, 32'h0);
    check({name, "_rvalid"}, {31'b0, bus.rvalid}, 32'h1);
    check(name, bus.rdata, exp);
  endtask

  task automatic bad(input logic r, input logic w, input logic [1:0] sz,
                     input logic [31:0] a, input string name);
    req(r, w, sz, 1'b0, a, 32'hCAFEF00D);
    check(name, {31'b0, bus.err}, 32'h1);
  endtask

  task automatic wait_init(input int expc, input string name);
    int c;
    c = 0;
    while (!bus.init_done && c < 2000) begin
      @(negedge clk);
      c++;
    end
    check(name, c, expc);
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.rd = 1'b0; bus.wr = 1'b0; bus.size = 2'd0;
    bus.sext = 1'b0; bus.addr = 32'h0; bus.wdata = 32'h0;

    // T1: one reset cycle, then the sweep holds ready low for RAM_SIZE cycles
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    wait_init(256, "t1_init_cycles");
    load(2'd2, 1'b0, 32'h3FC, 32'h0000_0000, "t1_ld3fc");

    // T2: word then byte overwrites
    store(2'd2, 32'h10, 32'h1122_3344);
    store(2'd0, 32'h11, 32'h0000_00AA);
    store(2'd0, 32'h13, 32'h0000_00BB);
    load(2'd2, 1'b0, 32'h10, 32'hBB22_AA44, "t2_word");

    // T3: extension
    load(2'd0, 1'b1, 32'h13, 32'hFFFF_FFBB, "t3_byte_sx");
    load(2'd0, 1'b0, 32'h13, 32'h0000_00BB, "t3_byte_zx");
    load(2'd1, 1'b1, 32'h12, 32'hFFFF_BB22, "t3_half_sx");
    load(2'd1, 1'b0, 32'h10, 32'h0000_AA44, "t3_half_lo");

    // T4: faults leave memory untouched
    bad(1'b1, 1'b0, 2'd2, 32'h12, "t4_word_misalign");
    bad(1'b0, 1'b1, 2'd1, 32'h11, "t4_half_misalign");
    bad(1'b1, 1'b0, 2'd3, 32'h10, "t4_size3");
    bad(1'b1, 1'b1, 2'd2, 32'h10, "t4_rd_wr");
    load(2'd2, 1'b0, 32'h10, 32'hBB22_AA44, "t4_unchanged");

    // T5: IO window
    store(2'd2, 32'h4000_0010, 32'hDEAD_BEEF);
    load(2'd2, 1'b0, 32'h10, 32'hBB22_AA44, "t5_old");
    load(2'd2, 1'b0, 32'h4000_0010, 32'h0000_0000, "t5_io");

    // Store then load of the same word on the next cycle; upper bits alias
    store(2'd1, 32'h22, 32'h0000_5566);
    load(2'd2, 1'b0, 32'h20, 32'h5566_0000, "st_ld_fwd");
    load(2'd0, 1'b1, 32'h0000_0423, 32'h0000_0055, "alias_byte");

    // T6: reset in mid-sweep restarts the full sweep
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (100) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    wait_init(256, "t6_restart_cycles");

    // Reset on the accept edge of a load suppresses its result
    bus.rd = 1'b1; bus.wr = 1'b0; bus.size = 2'd2; bus.addr = 32'h10;
    bus.req_valid = 1'b1; reset = 1'b1;
    @(negedge clk);
    check("t6_rvalid_reset", {31'b0, bus.rvalid}, 32'h0);
    bus.req_valid = 1'b0; bus.rd = 1'b0; reset = 1'b0;
    wait_init(256, "t6_reinit_cycles");
    load(2'd2, 1'b0, 32'h10, 32'h0000_0000, "t6_cleared");

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
